// File: rtl/stage_5_wb_ldwait_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_5_wb_ldwait_if
// Purpose  : MEM->WB handshake/bus, load-response, RF write, debug trace
//            and ID-forwarding signals of the writeback stage.
//            master = surrounding pipeline, slave = writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface stage_5_wb_ldwait_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RF_AW  = 5
);
    localparam int BUS_W = 7 + RF_AW + DATA_W + PC_W;

    // MEM -> WB handshake and bus
    logic              valid_4;
    logic              allow_5;
    logic [BUS_W-1:0]  stage_4_to_5;
    logic              flush;

    // Late load response
    logic              data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Register file write port and debug trace
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [PC_W-1:0]   debug_wb_pc;

    // Bypass / stall information towards ID
    logic              fwd_valid;
    logic [RF_AW-1:0]  fwd_dest;
    logic              fwd_pending;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output valid_4, stage_4_to_5, flush, data_ok, data_rdata,
        input  allow_5, rf_we, rf_waddr, rf_wdata, debug_wb_pc,
        input  fwd_valid, fwd_dest, fwd_pending, fwd_data
    );

    modport slave (
        input  valid_4, stage_4_to_5, flush, data_ok, data_rdata,
        output allow_5, rf_we, rf_waddr, rf_wdata, debug_wb_pc,
        output fwd_valid, fwd_dest, fwd_pending, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/stage_5_wb_ldwait.sv
`default_nettype none
// ============================================================================
// Module   : stage_5_wb_ldwait
// Purpose  : Writeback stage with valid/allow handshake that absorbs late
//            load data (byte/half extraction), forwards its pending write to
//            ID and drains one outstanding load response after a flush.
// Options  : WB_RETIRE_CNT_EN - adds a 32-bit retired-cycle counter port.
// Revision : 1.0 - initial release
// ============================================================================
module stage_5_wb_ldwait #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RF_AW  = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    stage_5_wb_ldwait_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]         retire_cnt
`endif
);

    localparam int BUS_W  = 7 + RF_AW + DATA_W + PC_W;

    // Field positions inside the packed MEM->WB bus
    localparam int POS_RES  = PC_W;
    localparam int POS_DEST = PC_W + DATA_W;
    localparam int POS_WE   = POS_DEST + RF_AW;
    localparam int POS_ALO  = POS_WE + 1;
    localparam int POS_OP   = POS_ALO + 2;
    localparam int POS_LD   = POS_OP + 3;

    // State encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Load operation codes
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic [1:0]        state_q, state_d;
    logic [BUS_W-1:0]  bus_q, bus_d;
    logic [DATA_W-1:0] ld_q, ld_d;

    logic              w_allow;
    logic              w_accept;
    logic              w_in_is_load;
    logic              w_capture;

    // Fields of the held instruction
    logic [PC_W-1:0]   w_pc;
    logic [DATA_W-1:0] w_result;
    logic [RF_AW-1:0]  w_dest;
    logic              w_we;
    logic [1:0]        w_alo;
    logic [2:0]        w_op;
    logic              w_is_load;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ld_ext;
    logic [DATA_W-1:0] w_value;

    assign w_pc      = bus_q[PC_W-1:0];
    assign w_result  = bus_q[POS_RES +: DATA_W];
    assign w_dest    = bus_q[POS_DEST +: RF_AW];
    assign w_we      = bus_q[POS_WE];
    assign w_alo     = bus_q[POS_ALO +: 2];
    assign w_op      = bus_q[POS_OP +: 3];
    assign w_is_load = bus_q[POS_LD];

    assign w_in_is_load = wb.stage_4_to_5[POS_LD];
    assign w_allow      = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign w_accept     = wb.valid_4 && w_allow && !wb.flush;

    // Load response is kept either while waiting for it or when it arrives
    // together with the accepted load itself.
    assign w_capture = ((state_q == ST_WAIT) && wb.data_ok && !wb.flush) ||
                       (w_accept && w_in_is_load && wb.data_ok);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush dominates every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (wb.flush) begin
                    state_d = ST_IDLE;
                end else if (w_accept) begin
                    if (w_in_is_load && !wb.data_ok) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_READY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wb.flush) begin
                    state_d = wb.data_ok ? ST_IDLE : ST_DRAIN;
                end else if (wb.data_ok) begin
                    state_d = ST_READY;
                end
            end
            ST_DRAIN: begin
                // The killed load's response is consumed and discarded
                if (wb.data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and load-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q <= '0;
            ld_q  <= '0;
        end else begin
            bus_q <= bus_d;
            ld_q  <= ld_d;
        end
    end

    // Datapath register updates: latch bus on accept, load word on capture
    always_comb begin
        bus_d = bus_q;
        ld_d  = ld_q;
        if (w_accept) begin
            bus_d = wb.stage_4_to_5;
        end
        if (w_capture) begin
            ld_d = wb.data_rdata;
        end
    end

    // Byte/half selection and sign/zero extension of the captured load word
    always_comb begin
        w_byte   = ld_q[{w_alo, 3'b000} +: 8];
        w_half   = ld_q[{w_alo[1], 4'b0000} +: 16];
        w_ld_ext = ld_q;
        case (w_op)
            OP_LB:   w_ld_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LBU:  w_ld_ext = {{(DATA_W-8){1'b0}}, w_byte};
            OP_LH:   w_ld_ext = {{(DATA_W-16){w_half[15]}}, w_half};
            OP_LHU:  w_ld_ext = {{(DATA_W-16){1'b0}}, w_half};
            default: w_ld_ext = ld_q;
        endcase
        w_value = w_is_load ? w_ld_ext : w_result;
    end

    // Output decode: retire in READY, forward from READY/WAIT
    always_comb begin
        wb.allow_5     = w_allow;
        wb.rf_we       = 1'b0;
        wb.rf_waddr    = '0;
        wb.rf_wdata    = '0;
        wb.debug_wb_pc = '0;
        wb.fwd_valid   = 1'b0;
        wb.fwd_dest    = '0;
        wb.fwd_pending = 1'b0;
        wb.fwd_data    = '0;
        if (state_q == ST_READY) begin
            wb.rf_we       = w_we && !wb.flush;
            wb.rf_waddr    = w_dest;
            wb.rf_wdata    = w_value;
            wb.debug_wb_pc = w_pc;
        end
        if (((state_q == ST_READY) || (state_q == ST_WAIT)) &&
            w_we && (w_dest != '0)) begin
            wb.fwd_valid   = 1'b1;
            wb.fwd_dest    = w_dest;
            wb.fwd_pending = (state_q == ST_WAIT);
            wb.fwd_data    = (state_q == ST_READY) ? w_value : '0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Retired-cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Count every READY cycle that is not killed; wraps naturally
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if ((state_q == ST_READY) && !wb.flush) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_5_wb_ldwait.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_5_wb_ldwait
// Purpose  : Self-checking bench for stage_5_wb_ldwait: directed scenarios
//            followed by random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_5_wb_ldwait;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    stage_5_wb_ldwait_if #(.DATA_W(32), .PC_W(32), .RF_AW(5)) bus_if ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    stage_5_wb_ldwait #(.DATA_W(32), .PC_W(32), .RF_AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (bus_if)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what WB is holding, described with flags
    logic        m_occ;     // an instruction is held
    logic        m_have;    // its load data has arrived
    logic        m_drain;   // a killed load's response is still owed
    logic [75:0] m_bus;
    logic [31:0] m_ldata;
    logic [31:0] m_cnt;

    function automatic logic [75:0] mk(input logic ld, input logic [2:0] op,
                                       input logic [1:0] alo, input logic we,
                                       input logic [4:0] dest, input logic [31:0] res,
                                       input logic [31:0] pc);
        return {ld, op, alo, we, dest, res, pc};
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] a,
                                        input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle and compare all outputs with the model
    task automatic drive(input logic v, input logic [75:0] b, input logic fl,
                         input logic dok, input logic [31:0] rd);
        logic        is_ld;
        logic        ready;
        logic        fv;
        logic [31:0] val;
        bus_if.valid_4      = v;
        bus_if.stage_4_to_5 = b;
        bus_if.flush        = fl;
        bus_if.data_ok      = dok;
        bus_if.data_rdata   = rd;
        #3;
        is_ld = m_bus[75];
        ready = m_occ && (!is_ld || m_have);
        val   = is_ld ? ext(m_bus[74:72], m_bus[71:70], m_ldata) : m_bus[63:32];
        fv    = m_occ && m_bus[69] && (m_bus[68:64] != 5'd0);
        chk("allow_5",     bus_if.allow_5,     !m_drain && !(m_occ && is_ld && !m_have));
        chk("rf_we",       bus_if.rf_we,       ready && m_bus[69] && !fl);
        chk("rf_waddr",    bus_if.rf_waddr,    ready ? m_bus[68:64] : 5'd0);
        chk("rf_wdata",    bus_if.rf_wdata,    ready ? val : 32'd0);
        chk("debug_wb_pc", bus_if.debug_wb_pc, ready ? m_bus[31:0] : 32'd0);
        chk("fwd_valid",   bus_if.fwd_valid,   fv);
        chk("fwd_dest",    bus_if.fwd_dest,    fv ? m_bus[68:64] : 5'd0);
        chk("fwd_pending", bus_if.fwd_pending, fv && !ready);
        chk("fwd_data",    bus_if.fwd_data,    (fv && ready) ? val : 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt",  retire_cnt,         m_cnt);
`endif
    endtask

    // Advance the model to the coming clock edge, then clock the DUT
    task automatic tick();
        logic allow;
        logic acc;
        logic waiting;
        waiting = m_occ && m_bus[75] && !m_have;
        allow   = !m_drain && !waiting;
        acc     = bus_if.valid_4 && allow && !bus_if.flush;
        if (reset) begin
            m_occ = 0; m_have = 0; m_drain = 0; m_bus = '0; m_ldata = '0; m_cnt = '0;
        end else begin
            if (m_occ && !waiting && !bus_if.flush) m_cnt = m_cnt + 32'd1;
            if (m_drain) begin
                if (bus_if.data_ok) m_drain = 0;
            end else if (bus_if.flush) begin
                m_drain = waiting && !bus_if.data_ok;
                m_occ   = 0;
            end else if (waiting) begin
                if (bus_if.data_ok) begin
                    m_have  = 1;
                    m_ldata = bus_if.data_rdata;
                end
            end else if (acc) begin
                m_occ  = 1;
                m_bus  = bus_if.stage_4_to_5;
                m_have = 0;
                if (m_bus[75] && bus_if.data_ok) begin
                    m_have  = 1;
                    m_ldata = bus_if.data_rdata;
                end
            end else begin
                m_occ = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [75:0] b;
        logic        v, fl, dok, waiting;
        errors = 0;
        checks = 0;
        m_occ = 0; m_have = 0; m_drain = 0; m_bus = '0; m_ldata = '0; m_cnt = '0;
        reset = 1'b1;
        idle(); tick();
        idle(); tick();
        reset = 1'b0;

        // Reset state
        idle();
        chk("reset_allow", bus_if.allow_5, 1'b1);
        chk("reset_rf_we", bus_if.rf_we, 1'b0);
        tick();

        // ALU instruction retires one cycle later
        drive(1'b1, mk(0, 3'd0, 2'd0, 1, 5'd5, 32'h1234, 32'h1c00_0000), 0, 0, '0); tick();
        idle();
        chk("alu_we",    bus_if.rf_we, 1'b1);
        chk("alu_waddr", bus_if.rf_waddr, 5'd5);
        chk("alu_wdata", bus_if.rf_wdata, 32'h1234);
        chk("alu_pc",    bus_if.debug_wb_pc, 32'h1c00_0000);
        tick();

        // LB addr_lo=3, response two cycles after accept
        drive(1'b1, mk(1, 3'd1, 2'd3, 1, 5'd7, 32'hDEAD, 32'h1c00_0004), 0, 0, '0); tick();
        idle();
        chk("lb_allow0",   bus_if.allow_5, 1'b0);
        chk("lb_pending",  bus_if.fwd_pending, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1, 32'h80FF_FF00);
        chk("lb_we_at_ok", bus_if.rf_we, 1'b0);
        tick();
        idle();
        chk("lb_we",    bus_if.rf_we, 1'b1);
        chk("lb_wdata", bus_if.rf_wdata, 32'hFFFF_FF80);
        tick();

        // LHU addr_lo=2 with response in the accept cycle
        drive(1'b1, mk(1, 3'd4, 2'd2, 1, 5'd9, 32'h0, 32'h1c00_0008), 0, 1, 32'hBEEF_0000); tick();
        idle();
        chk("lhu_wdata", bus_if.rf_wdata, 32'h0000_BEEF);
        tick();

        // Flush while waiting; response three cycles later is drained
        drive(1'b1, mk(1, 3'd0, 2'd0, 1, 5'd3, 32'h0, 32'h1c00_000c), 0, 0, '0); tick();
        drive(1'b0, '0, 1, 0, '0);
        chk("fl_we", bus_if.rf_we, 1'b0);
        tick();
        idle(); chk("drain_allow", bus_if.allow_5, 1'b0); tick();
        idle(); tick();
        drive(1'b0, '0, 0, 1, 32'h5555_5555);
        chk("drain_we", bus_if.rf_we, 1'b0);
        tick();
        drive(1'b1, mk(0, 3'd0, 2'd0, 1, 5'd4, 32'hCAFE, 32'h1c00_0010), 0, 0, '0);
        chk("post_drain_allow", bus_if.allow_5, 1'b1);
        tick();
        idle(); chk("post_drain_we", bus_if.rf_we, 1'b1); tick();

        // Four back-to-back ALU instructions after a fresh reset
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(0, 3'd0, 2'd0, 1, 5'(i + 10), 32'(i * 3 + 1), 32'h1c00_0100 + 32'(4 * i)), 0, 0, '0);
            if (i > 0) chk("b2b_we", bus_if.rf_we, 1'b1);
            tick();
        end
        idle(); chk("b2b_we_last", bus_if.rf_we, 1'b1); tick();
        idle();
`ifdef WB_RETIRE_CNT_EN
        chk("b2b_cnt", retire_cnt, 32'd4);
`endif
        tick();

        // Reset in the middle of a wait
        drive(1'b1, mk(1, 3'd0, 2'd0, 1, 5'd6, 32'h0, 32'h1c00_0200), 0, 0, '0); tick();
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        idle();
        chk("rst_we",    bus_if.rf_we, 1'b0);
        chk("rst_allow", bus_if.allow_5, 1'b1);
        chk("rst_fwd",   bus_if.fwd_valid, 1'b0);
        tick();
        drive(1'b0, '0, 0, 1, 32'h1111_1111); tick();
        idle(); chk("rst_ok_ignored", bus_if.allow_5, 1'b1); tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            waiting = (m_occ && m_bus[75] && !m_have) || m_drain;
            v  = ($urandom_range(0, 2) != 0);
            b  = mk($urandom_range(0, 1), 3'($urandom_range(0, 7)), 2'($urandom),
                    ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    $urandom, $urandom);
            fl = ($urandom_range(0, 9) == 0);
            if (waiting) dok = ($urandom_range(0, 2) == 0);
            else         dok = ($urandom_range(0, 7) == 0);
            if (m_drain && dok) fl = 1'b0;
            drive(v, b, fl, dok, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
